// File: rtl/dmem_ctrl_if.sv
// Data-memory bus between dmem_ctrl (master) and the memory/interconnect (slave).
// Variable-latency req/ack handshake; request fields are held stable until acked.
interface dmem_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/dmem_ctrl.sv
// M-stage data-memory controller: core LDR/STR to req/ack bus, with stall, timeout and error flag.
// Define DMEM_WBUF_EN to add a one-entry posted write buffer (entry lives on the bus regs in DRAIN).
module dmem_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        MemErr,
    dmem_ctrl_if.master bus
);
`ifdef DMEM_WBUF_EN
    localparam bit WBUF = 1'b1;
`else
    localparam bit WBUF = 1'b0;
`endif

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] DRAIN   = 3'd1;
    localparam logic [2:0] RD_WAIT = 3'd2;
    localparam logic [2:0] WR_WAIT = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    localparam int             CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [31:0]    BAD_DATA = 32'hDEADBEEF;

    logic [2:0]        state;
    logic              reqQ, weQ, errQ;
    logic [ADDR_W-1:0] addrQ;
    logic [31:0]       wdataQ, rdQ;
    logic [CW-1:0]     cnt;

    logic              misal, reqErr, rdOk, wrOk, hit, cntHit;
    logic [ADDR_W-1:0] wordAddr;

    assign misal    = |ALUOutM[1:0];
    assign reqErr   = (MemReadM | MemWriteM) & (misal | (MemReadM & MemWriteM));
    assign rdOk     = MemReadM & ~MemWriteM & ~misal;
    assign wrOk     = MemWriteM & ~MemReadM & ~misal;
    assign wordAddr = {ALUOutM[ADDR_W-1:2], 2'b00};
    // Bus regs hold the buffered store while draining, so they double as the wbuf entry.
    assign hit      = WBUF && (state == DRAIN) && rdOk && (addrQ[ADDR_W-1:2] == ALUOutM[ADDR_W-1:2]);
    // Fires on the TIMEOUT-th request cycle without an ack.
    assign cntHit   = (cnt == CNT_LAST);

    assign bus.mem_req   = reqQ;
    assign bus.mem_we    = weQ;
    assign bus.mem_addr  = addrQ;
    assign bus.mem_wdata = wdataQ;
    assign MemErr        = errQ;

    always_comb begin
        StallM    = 1'b0;
        ReadDataM = rdQ;
        case (state)
            IDLE: begin
                if (reqErr) ReadDataM = '0;
                else        StallM = rdOk | (wrOk & ~WBUF);
            end
            RD_WAIT, WR_WAIT: StallM = 1'b1;
            DRAIN: begin
                if (reqErr)     ReadDataM = '0;
                else if (hit)   ReadDataM = wdataQ;
                else if (rdOk)  StallM = 1'b1;
                else if (wrOk)  StallM = ~bus.mem_ack;
            end
            default: ;
        endcase
        if (!rst) StallM = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            reqQ   <= 1'b0;
            weQ    <= 1'b0;
            errQ   <= 1'b0;
            addrQ  <= '0;
            wdataQ <= '0;
            rdQ    <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (reqErr) begin
                        errQ <= 1'b1;
                        rdQ  <= '0;
                    end else if (rdOk) begin
                        state <= RD_WAIT;
                        reqQ  <= 1'b1;
                        weQ   <= 1'b0;
                        addrQ <= wordAddr;
                    end else if (wrOk) begin
                        state  <= WBUF ? DRAIN : WR_WAIT;
                        reqQ   <= 1'b1;
                        weQ    <= 1'b1;
                        addrQ  <= wordAddr;
                        wdataQ <= WriteDataM;
                    end
                end
                RD_WAIT, WR_WAIT: begin
                    if (bus.mem_ack) begin
                        if (state == RD_WAIT) rdQ <= bus.mem_rdata;
                        reqQ  <= 1'b0;
                        weQ   <= 1'b0;
                        state <= DONE;
                    end else if (cntHit) begin
                        if (state == RD_WAIT) rdQ <= BAD_DATA;
                        errQ  <= 1'b1;
                        reqQ  <= 1'b0;
                        weQ   <= 1'b0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (reqErr) begin
                        errQ <= 1'b1;
                        rdQ  <= '0;
                    end else if (hit) begin
                        rdQ <= wdataQ;
                    end
                    if (bus.mem_ack) begin
                        // A store waiting on the full buffer refills it on the drain-ack edge.
                        if (wrOk) begin
                            addrQ  <= wordAddr;
                            wdataQ <= WriteDataM;
                            cnt    <= '0;
                        end else begin
                            reqQ  <= 1'b0;
                            weQ   <= 1'b0;
                            state <= IDLE;
                        end
                    end else if (cntHit) begin
                        errQ  <= 1'b1;
                        reqQ  <= 1'b0;
                        weQ   <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
